intc_ack_master: RTL and testbench

- AXI-Lite master that services the SoC interrupt controller on behalf of a simple vector consumer, such as a CPU trap unit or a DMA sequencer.
- When irq_i is high, it reads the controller's Interrupt Vector Register (IVR) and presents the vector to the consumer.
- After the consumer acknowledges, it writes the matching bit to the Interrupt Acknowledge Register (IAR).
- Sits between the intc irq output and the controller's AXI-Lite slave port; it drives the requesting end of that port.

---
 rtl/intc_ack_master_pkg.sv | 21 ++
 rtl/intc_ack_master_if.sv | 35 +++
 rtl/intc_ack_master_axil_wr_pair.sv | 37 +++
 rtl/intc_ack_master.sv | 174 +++++++++++++++++
 tb/tb_intc_ack_master.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intc_ack_master_pkg.sv
// Shared constants and the state type for the interrupt-acknowledge master.
package intc_ack_pkg;

  // Controller register offsets within its AXI-Lite window
  localparam logic [8:0]  IVR_OFF   = 9'h18;
  localparam logic [8:0]  IAR_OFF   = 9'h0C;

  // AXI response code and the IVR value meaning "nothing pending"
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] IVR_NONE  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    VEC,
    WR,
    B
  } state_t;

endpackage

// File: rtl/intc_ack_master_if.sv
// AXI-Lite link between the acknowledge master and the interrupt controller.
interface intc_ack_master_if #(
  parameter int ADDR_W = 9
) ();

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/intc_ack_master_axil_wr_pair.sv
// Drives AW/W valids for one IAR write; each channel drops independently once
// accepted, and done rises on the cycle the second channel is accepted.
module axil_wr_pair (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic done
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  // Sticky per-channel accept flags, cleared whenever no write is in progress
  always_comb begin
    awvalid   = active & ~aw_done_q;
    wvalid    = active & ~w_done_q;
    aw_done_d = active & (aw_done_q | (awvalid & awready));
    w_done_d  = active & (w_done_q | (wvalid & wready));
    done      = aw_done_d & w_done_d;
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/intc_ack_master.sv
// AXI-Lite master that reads the interrupt controller IVR, hands the vector to
// a consumer and, once acknowledged, writes the matching IAR bit.
// Optional: define INTC_ACK_TIMEOUT_EN to bound the R and B response waits by
// TIMEOUT_CYC cycles; otherwise those states wait indefinitely.
module intc_ack_master
  import intc_ack_pkg::*;
#(
  parameter int              ADDR_W      = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              NUM_INTR    = 8,
  parameter int              TIMEOUT_CYC = 256
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        en_i,
  input  logic                        irq_i,
  output logic [$clog2(NUM_INTR)-1:0] vec_o,
  output logic                        vec_valid_o,
  input  logic                        vec_ready_i,
  output logic                        spurious_o,
  output logic                        err_o,
  output logic                        busy_o,
  intc_ack_master_if.master           m_axi
);

  localparam int VEC_W = $clog2(NUM_INTR);

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic              err_q, err_d;
  logic              spur_q, spur_d;
  logic              hold_q, hold_d;
  logic              wr_done;

`ifdef INTC_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout;
`endif

  axil_wr_pair u_wr_pair (
    .clk     (aclk),
    .rst     (areset),
    .active  (state_q == WR),
    .awready (m_axi.awready),
    .wready  (m_axi.wready),
    .awvalid (m_axi.awvalid),
    .wvalid  (m_axi.wvalid),
    .done    (wr_done)
  );

  // Bus-side outputs decoded from the current state; everything idles at zero
  always_comb begin
    m_axi.araddr  = '0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    m_axi.awaddr  = '0;
    m_axi.wdata   = '0;
    m_axi.wstrb   = '0;
    m_axi.bready  = 1'b0;
    case (state_q)
      AR: begin
        m_axi.araddr  = BASE_ADDR + ADDR_W'(IVR_OFF);
        m_axi.arvalid = 1'b1;
      end
      R:  m_axi.rready = 1'b1;
      WR: begin
        m_axi.awaddr = BASE_ADDR + ADDR_W'(IAR_OFF);
        m_axi.wdata  = 32'd1 << vec_q;
        m_axi.wstrb  = 4'hF;
      end
      B:  m_axi.bready = 1'b1;
      default: ;
    endcase
  end

`ifdef INTC_ACK_TIMEOUT_EN
  // Response-wait counter: restarts on every entry to R or B
  always_comb begin
    timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    cnt_d   = '0;
    if (((state_q == R) || (state_q == B)) && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`endif

  // Next-state logic; the hold flag forces one idle cycle after the IAR write
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = 1'b0;
    spur_d  = 1'b0;
    hold_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hold_q && en_i && irq_i) state_d = AR;
      end
      AR: begin
        if (m_axi.arready) state_d = R;
      end
      R: begin
        if (m_axi.rvalid) begin
          if (m_axi.rresp != RESP_OKAY) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (m_axi.rdata == IVR_NONE) begin
            spur_d  = 1'b1;
            state_d = IDLE;
          end else begin
            vec_d   = m_axi.rdata[VEC_W-1:0];
            state_d = VEC;
          end
        end
`ifdef INTC_ACK_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      VEC: begin
        if (vec_ready_i) state_d = WR;
      end
      WR: begin
        if (wr_done) state_d = B;
      end
      B: begin
        if (m_axi.bvalid) begin
          err_d   = (m_axi.bresp != RESP_OKAY);
          hold_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef INTC_ACK_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; reset wins over any in-flight handshake
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= 1'b0;
      spur_q  <= 1'b0;
      hold_q  <= 1'b0;
`ifdef INTC_ACK_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      spur_q  <= spur_d;
      hold_q  <= hold_d;
`ifdef INTC_ACK_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign vec_o       = vec_q;
  assign vec_valid_o = (state_q == VEC);
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;
  assign spurious_o  = spur_q;

endmodule

// File: tb/tb_intc_ack_master.sv
// Self-checking bench for intc_ack_master: the bench acts as the AXI-Lite
// slave and the vector consumer, and a scoreboard matches every bus
// handshake, vector presentation and status pulse against expectations.
module tb_intc_ack_master;

  logic       aclk = 1'b0;
  logic       areset;
  logic       en_i;
  logic       irq_i;
  logic [2:0] vec_o;
  logic       vec_valid_o;
  logic       vec_ready_i;
  logic       spurious_o;
  logic       err_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ar[$];
  logic [31:0] exp_vec[$];
  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_err[$];
  logic [31:0] exp_spur[$];

  intc_ack_master_if #(.ADDR_W(9)) m_axi ();

  intc_ack_master #(
    .ADDR_W      (9),
    .BASE_ADDR   (9'h000),
    .NUM_INTR    (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .en_i        (en_i),
    .irq_i       (irq_i),
    .vec_o       (vec_o),
    .vec_valid_o (vec_valid_o),
    .vec_ready_i (vec_ready_i),
    .spurious_o  (spurious_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .m_axi       (m_axi)
  );

  always #5 aclk = ~aclk;

  // Scoreboard monitor: samples on the falling edge and pops expectations
  logic        vv_prev = 1'b0;
  logic [31:0] mon_e;
  always @(negedge aclk) begin
    if (areset) begin
      vv_prev = 1'b0;
    end else begin
      if (m_axi.arvalid && m_axi.arready) begin
        checks++;
        if (exp_ar.size() == 0) begin
          errors++; $display("[TB] FAIL ar_unexpected: got araddr %h, required no AR", m_axi.araddr);
        end else begin
          mon_e = exp_ar.pop_front();
          if (32'(m_axi.araddr) !== mon_e) begin
            errors++; $display("[TB] FAIL ar_addr: got %h required %h", m_axi.araddr, mon_e);
          end
        end
      end
      if (vec_valid_o && !vv_prev) begin
        checks++;
        if (exp_vec.size() == 0) begin
          errors++; $display("[TB] FAIL vec_unexpected: got vec %0d, required none", vec_o);
        end else begin
          mon_e = exp_vec.pop_front();
          if (32'(vec_o) !== mon_e) begin
            errors++; $display("[TB] FAIL vec_value: got %0d required %0d", vec_o, mon_e);
          end
        end
      end
      vv_prev = vec_valid_o;
      if (m_axi.awvalid && m_axi.awready) begin
        checks++;
        if (exp_aw.size() == 0) begin
          errors++; $display("[TB] FAIL aw_unexpected: got awaddr %h, required no AW", m_axi.awaddr);
        end else begin
          mon_e = exp_aw.pop_front();
          if (32'(m_axi.awaddr) !== mon_e) begin
            errors++; $display("[TB] FAIL aw_addr: got %h required %h", m_axi.awaddr, mon_e);
          end
        end
      end
      if (m_axi.wvalid && m_axi.wready) begin
        checks++;
        if (exp_w.size() == 0) begin
          errors++; $display("[TB] FAIL w_unexpected: got wdata %h, required no W", m_axi.wdata);
        end else begin
          mon_e = exp_w.pop_front();
          if ({m_axi.wstrb, m_axi.wdata} !== {4'hF, mon_e}) begin
            errors++; $display("[TB] FAIL w_data: got strb %h data %h required strb f data %h",
                               m_axi.wstrb, m_axi.wdata, mon_e);
          end
        end
      end
      if (err_o !== 1'b0) begin
        checks++;
        if (exp_err.size() == 0) begin
          errors++; $display("[TB] FAIL err_unexpected: got err_o %b, required 0", err_o);
        end else begin
          void'(exp_err.pop_front());
        end
      end
      if (spurious_o !== 1'b0) begin
        checks++;
        if (exp_spur.size() == 0) begin
          errors++; $display("[TB] FAIL spur_unexpected: got spurious_o %b, required 0", spurious_o);
        end else begin
          void'(exp_spur.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic slave_ar();
    int n = 0;
    while (m_axi.arvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (m_axi.arvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL ar_wait: got arvalid %b after %0d cycles, required 1", m_axi.arvalid, n);
    end else begin
      m_axi.arready = 1'b1; tick(); m_axi.arready = 1'b0;
    end
  endtask

  task automatic slave_r(input logic [31:0] data, input logic [1:0] resp);
    int n = 0;
    m_axi.rvalid = 1'b1; m_axi.rdata = data; m_axi.rresp = resp;
    while (m_axi.rready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (m_axi.rready !== 1'b1) begin
      errors++; $display("[TB] FAIL r_wait: got rready %b after %0d cycles, required 1", m_axi.rready, n);
    end
    tick();
    m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = '0;
  endtask

  task automatic slave_wr(input int aw_dly, input int w_dly);
    int n = 0;
    int last = (aw_dly > w_dly) ? aw_dly : w_dly;
    while (m_axi.awvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (m_axi.awvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_wait: got awvalid %b after %0d cycles, required 1", m_axi.awvalid, n);
    end else begin
      for (int c = 0; c <= last; c++) begin
        m_axi.awready = (c == aw_dly); m_axi.wready = (c == w_dly); tick();
      end
    end
    m_axi.awready = 1'b0; m_axi.wready = 1'b0;
  endtask

  task automatic slave_b(input logic [1:0] resp);
    int n = 0;
    m_axi.bvalid = 1'b1; m_axi.bresp = resp;
    while (m_axi.bready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (m_axi.bready !== 1'b1) begin
      errors++; $display("[TB] FAIL b_wait: got bready %b after %0d cycles, required 1", m_axi.bready, n);
    end
    tick();
    m_axi.bvalid = 1'b0; m_axi.bresp = '0;
  endtask

  task automatic consume_vec(input int hold);
    repeat (hold) tick();
    vec_ready_i = 1'b1; tick(); vec_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; en_i = 1'b0; irq_i = 1'b0; vec_ready_i = 1'b0;
    m_axi.arready = 0; m_axi.rdata = 0; m_axi.rresp = 0; m_axi.rvalid = 0;
    m_axi.awready = 0; m_axi.wready = 0; m_axi.bresp = 0; m_axi.bvalid = 0;
    repeat (3) tick();
    checks++;
    if ({busy_o, vec_valid_o, vec_o, err_o, spurious_o} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_status: got %b required 0", {busy_o, vec_valid_o, vec_o, err_o, spurious_o});
    end
    checks++;
    if ({m_axi.arvalid, m_axi.araddr, m_axi.rready} !== 11'b0) begin
      errors++; $display("[TB] FAIL reset_read_ch: got %h required 0", {m_axi.arvalid, m_axi.araddr, m_axi.rready});
    end
    checks++;
    if ({m_axi.awvalid, m_axi.awaddr, m_axi.wvalid, m_axi.wdata, m_axi.wstrb, m_axi.bready} !== 48'b0) begin
      errors++; $display("[TB] FAIL reset_write_ch: got %h required 0",
                         {m_axi.awvalid, m_axi.awaddr, m_axi.wvalid, m_axi.wdata, m_axi.wstrb, m_axi.bready});
    end
    areset = 1'b0; en_i = 1'b1; tick();
  endtask

  task automatic test_basic();
    int bad = 0;
    exp_ar.push_back(32'h18); exp_vec.push_back(32'd3);
    exp_aw.push_back(32'h0C); exp_w.push_back(32'h8);
    irq_i = 1'b1; tick();
    checks++;
    if (m_axi.arvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL ar_latency: got arvalid %b one cycle after irq, required 1", m_axi.arvalid);
    end
    slave_ar();
    slave_r(32'h3, 2'b00);
    checks++;
    if ({vec_valid_o, vec_o} !== 4'b1_011) begin
      errors++; $display("[TB] FAIL vec_latency: got valid/vec %b required 1011", {vec_valid_o, vec_o});
    end
    repeat (5) begin tick(); if ({vec_valid_o, vec_o} !== 4'b1_011) bad++; end
    vec_ready_i = 1'b1; tick(); vec_ready_i = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL vec_hold: got %0d unstable cycles required 0", bad);
    end
    checks++;
    if ({m_axi.awvalid, m_axi.wvalid, m_axi.awaddr, m_axi.wdata, m_axi.wstrb} !== {2'b11, 9'h0C, 32'h8, 4'hF}) begin
      errors++; $display("[TB] FAIL wr_issue: got %h required %h",
                         {m_axi.awvalid, m_axi.wvalid, m_axi.awaddr, m_axi.wdata, m_axi.wstrb},
                         {2'b11, 9'h0C, 32'h8, 4'hF});
    end
    slave_wr(0, 0);
    irq_i = 1'b0;
    slave_b(2'b00);
    checks++;
    if ({busy_o, err_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL basic_done: got busy/err %b required 00", {busy_o, err_o});
    end
    tick();
  endtask

  task automatic test_spurious();
    int bad = 0;
    exp_ar.push_back(32'h18); exp_spur.push_back(32'd1);
    irq_i = 1'b1; tick();
    slave_ar();
    irq_i = 1'b0;
    slave_r(32'hFFFF_FFFF, 2'b00);
    checks++;
    if ({spurious_o, busy_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL spur_pulse: got spur/busy %b required 10", {spurious_o, busy_o});
    end
    repeat (4) begin
      if (m_axi.awvalid || m_axi.wvalid || vec_valid_o) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || spurious_o !== 1'b0) begin
      errors++; $display("[TB] FAIL spur_no_write: got %0d write/vec cycles, spur %b, required 0 and 0", bad, spurious_o);
    end
  endtask

  task automatic test_aw_w_skew();
    int aw_d[3] = '{0, 3, 2};
    int w_d[3]  = '{3, 0, 2};
    int vecs[3] = '{1, 6, 7};
    for (int i = 0; i < 3; i++) begin
      int bad = 0;
      int last = (aw_d[i] > w_d[i]) ? aw_d[i] : w_d[i];
      exp_ar.push_back(32'h18); exp_vec.push_back(32'(vecs[i]));
      exp_aw.push_back(32'h0C); exp_w.push_back(32'd1 << vecs[i]);
      irq_i = 1'b1; tick();
      slave_ar();
      slave_r(32'(vecs[i]), 2'b00);
      consume_vec(1);
      for (int c = 0; c <= last; c++) begin
        m_axi.awready = (c == aw_d[i]); m_axi.wready = (c == w_d[i]);
        tick();
        if (c < last) begin
          if (c >= aw_d[i] && m_axi.awvalid !== 1'b0) bad++;
          if (c >= w_d[i] && m_axi.wvalid !== 1'b0) bad++;
          if (c < aw_d[i] && m_axi.awvalid !== 1'b1) bad++;
          if (c < w_d[i] && m_axi.wvalid !== 1'b1) bad++;
        end
      end
      m_axi.awready = 1'b0; m_axi.wready = 1'b0;
      irq_i = 1'b0;
      checks++;
      if (bad != 0 || {m_axi.bready, m_axi.awvalid, m_axi.wvalid} !== 3'b100) begin
        errors++; $display("[TB] FAIL skew_%0d: got %0d valid errors, bready/awvalid/wvalid %b, required 0 and 100",
                           i, bad, {m_axi.bready, m_axi.awvalid, m_axi.wvalid});
      end
      slave_b(2'b00);
      tick();
    end
  endtask

  task automatic test_rresp_err();
    exp_ar.push_back(32'h18); exp_err.push_back(32'd1);
    irq_i = 1'b1; tick();
    slave_ar();
    irq_i = 1'b0;
    slave_r(32'h5, 2'b10);
    checks++;
    if ({err_o, vec_valid_o, busy_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL rresp_err: got err/vv/busy %b required 100", {err_o, vec_valid_o, busy_o});
    end
    tick();
    checks++;
    if ({err_o, vec_valid_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL rresp_err_end: got err/vv %b required 00", {err_o, vec_valid_o});
    end
  endtask

  task automatic test_bresp_err();
    exp_ar.push_back(32'h18); exp_vec.push_back(32'd2);
    exp_aw.push_back(32'h0C); exp_w.push_back(32'h4); exp_err.push_back(32'd1);
    irq_i = 1'b1; tick();
    slave_ar();
    slave_r(32'h2, 2'b00);
    consume_vec(0);
    slave_wr(1, 0);
    irq_i = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL bresp_early: got err_o %b before B, required 0", err_o);
    end
    slave_b(2'b11);
    checks++;
    if ({err_o, busy_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL bresp_err: got err/busy %b required 10", {err_o, busy_o});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_ar.push_back(32'h18); exp_vec.push_back(32'd4);
    exp_aw.push_back(32'h0C); exp_w.push_back(32'h10);
    exp_ar.push_back(32'h18); exp_spur.push_back(32'd1);
    irq_i = 1'b1; tick();
    slave_ar();
    slave_r(32'h4, 2'b00);
    consume_vec(0);
    slave_wr(0, 0);
    slave_b(2'b00);
    tick();
    checks++;
    if ({busy_o, m_axi.arvalid} !== 2'b00) begin
      errors++; $display("[TB] FAIL idle_gap: got busy/arvalid %b in gap cycle, required 00", {busy_o, m_axi.arvalid});
    end
    tick();
    checks++;
    if (m_axi.arvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL resample: got arvalid %b after gap, required 1", m_axi.arvalid);
    end
    slave_ar();
    irq_i = 1'b0;
    slave_r(32'hFFFF_FFFF, 2'b00);
    tick();
  endtask

  task automatic test_reset_enable();
    int bad = 0;
    exp_ar.push_back(32'h18); exp_vec.push_back(32'd5);
    irq_i = 1'b1; tick();
    slave_ar();
    slave_r(32'h5, 2'b00);
    tick();
    checks++;
    if ({vec_valid_o, vec_o} !== 4'b1_101) begin
      errors++; $display("[TB] FAIL pre_reset_vec: got %b required 1101", {vec_valid_o, vec_o});
    end
    areset = 1'b1; tick();
    checks++;
    if ({busy_o, vec_valid_o, vec_o, err_o, spurious_o, m_axi.arvalid, m_axi.rready,
         m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.awaddr, m_axi.wdata} !== 53'b0) begin
      errors++; $display("[TB] FAIL mid_reset: got busy %b vv %b vec %0d arv %b awv %b wv %b, required all 0",
                         busy_o, vec_valid_o, vec_o, m_axi.arvalid, m_axi.awvalid, m_axi.wvalid);
    end
    areset = 1'b0; en_i = 1'b0; irq_i = 1'b1;
    repeat (6) begin tick(); if (m_axi.arvalid !== 1'b0 || busy_o !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL en_low: got %0d active cycles with en_i=0, required 0", bad);
    end
    irq_i = 1'b0; en_i = 1'b1; tick();
  endtask

`ifdef INTC_ACK_TIMEOUT_EN
  task automatic test_timeout();
    int bad = 0;
    exp_ar.push_back(32'h18); exp_err.push_back(32'd1);
    irq_i = 1'b1; tick();
    slave_ar();
    irq_i = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick(); if (err_o !== 1'b0 || m_axi.rready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL timeout_early: got %0d bad wait cycles, required 0", bad);
    end
    tick();
    checks++;
    if ({err_o, m_axi.rready, busy_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL timeout_fire: got err/rready/busy %b required 100", {err_o, m_axi.rready, busy_o});
    end
    bad = 0;
    m_axi.rvalid = 1'b1; m_axi.rdata = 32'h3;
    repeat (3) begin tick(); if (busy_o !== 1'b0 || vec_valid_o !== 1'b0) bad++; end
    m_axi.rvalid = 1'b0; m_axi.rdata = '0;
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL late_rvalid: got %0d active cycles, required 0", bad);
    end
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_spurious();
    test_aw_w_skew();
    test_rresp_err();
    test_bresp_err();
    test_back_to_back();
    test_reset_enable();
`ifdef INTC_ACK_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) tick();
    checks++;
    if (exp_ar.size() + exp_vec.size() + exp_aw.size() + exp_w.size() + exp_err.size() + exp_spur.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: got ar %0d vec %0d aw %0d w %0d err %0d spur %0d left, required 0",
                         exp_ar.size(), exp_vec.size(), exp_aw.size(), exp_w.size(), exp_err.size(), exp_spur.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
